// File: rtl/jedro_1_lsu.sv
// Load/store unit: one outstanding load or store on a req/gnt/rvalid data bus with
// register-file writeback. Optional bus-error reporting via `define JEDRO_1_LSU_ERR_EN.
module jedro_1_lsu #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  output logic                      ctrl_ready_o,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [31:0]               ctrl_addr_i,
  input  logic [DATA_WIDTH-1:0]     ctrl_wdata_i,
  input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [31:0]               data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_err_i,
  output logic                      rf_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_data_o,
  output logic                      done_o,
  output logic                      misaligned_o,
  output logic                      err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  logic [1:0]                state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic [1:0]                off_q, off_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
  logic                      done_q, done_d;
  logic                      mis_q, mis_d;
  logic                      err_q, err_d;

  logic                      legal_c;
  logic [3:0]                be_c;
  logic [DATA_WIDTH-1:0]     wdata_c;
  logic [DATA_WIDTH-1:0]     ld_shift_c;
  logic [DATA_WIDTH-1:0]     ld_data_c;
  logic                      bus_err_c;

`ifdef JEDRO_1_LSU_ERR_EN
  assign bus_err_c = data_err_i;
`else
  logic unused_err;
  assign unused_err = data_err_i;
  assign bus_err_c  = 1'b0;
`endif

  // Request decode: legality, byte enables and lane-replicated store data
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b1111;
    wdata_c = ctrl_wdata_i;
    case (ctrl_size_i)
      SIZE_B: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << ctrl_addr_i[1:0];
        wdata_c = {4{ctrl_wdata_i[7:0]}};
      end
      SIZE_H: begin
        legal_c = ~ctrl_addr_i[0];
        be_c    = 4'b0011 << ctrl_addr_i[1:0];
        wdata_c = {2{ctrl_wdata_i[15:0]}};
      end
      SIZE_W: begin
        legal_c = (ctrl_addr_i[1:0] == 2'b00);
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Load data alignment and sign/zero extension
  always_comb begin
    ld_shift_c = data_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SIZE_B:  ld_data_c = uns_q ? {24'd0, ld_shift_c[7:0]}
                                 : {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      SIZE_H:  ld_data_c = uns_q ? {16'd0, ld_shift_c[15:0]}
                                 : {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    rd_d      = rd_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    rf_we_d   = 1'b0;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_valid_i && ready_q) begin
          if (legal_c) begin
            state_d = ADDR;
            req_d   = 1'b1;
            we_d    = ctrl_we_i;
            be_d    = be_c;
            addr_d  = {ctrl_addr_i[31:2], 2'b00};
            wdata_d = wdata_c;
            size_d  = ctrl_size_i;
            uns_d   = ctrl_unsigned_i;
            off_d   = ctrl_addr_i[1:0];
            rd_d    = ctrl_rd_i;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (data_gnt_i) begin
          state_d = RESP;
          req_d   = 1'b0;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = bus_err_c;
          if (!we_q && !bus_err_c) begin
            rf_we_d   = 1'b1;
            rf_addr_d = rd_q;
            rf_data_d = ld_data_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= '0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      off_q     <= 2'd0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end

  assign ctrl_ready_o = ready_q;
  assign data_req_o   = req_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign rf_we_o      = rf_we_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_data_o    = rf_data_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
`ifdef JEDRO_1_LSU_ERR_EN
  assign err_o        = err_q;
`else
  assign err_o        = 1'b0;
  logic unused_err_q;
  assign unused_err_q = err_q;
`endif

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu: loads, stores, misalignment, back-to-back, reset abort, bus error.
module tb_jedro_1_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic        ctrl_we = 1'b0;
  logic [1:0]  ctrl_size = 2'b00;
  logic        ctrl_unsigned = 1'b0;
  logic [31:0] ctrl_addr = 32'd0;
  logic [31:0] ctrl_wdata = 32'd0;
  logic [4:0]  ctrl_rd = 5'd0;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic        data_rvalid = 1'b0;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata = 32'd0;
  logic        data_err = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        done;
  logic        misaligned;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jedro_1_lsu dut (
    .clk_i(clk), .rstn_i(rstn),
    .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready), .ctrl_we_i(ctrl_we),
    .ctrl_size_i(ctrl_size), .ctrl_unsigned_i(ctrl_unsigned), .ctrl_addr_i(ctrl_addr),
    .ctrl_wdata_i(ctrl_wdata), .ctrl_rd_i(ctrl_rd),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
    .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .data_err_i(data_err),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .done_o(done), .misaligned_o(misaligned), .err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    ctrl_valid    = 1'b1;
    ctrl_we       = we;
    ctrl_size     = size;
    ctrl_unsigned = uns;
    ctrl_addr     = addr;
    ctrl_wdata    = wdata;
    ctrl_rd       = rd;
  endtask

  initial begin
    // Reset: everything low, ready only after first released edge
    #1 rstn = 1'b0;
    #2;
    check("rst_ready", 32'(ctrl_ready), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_outs", {27'd0, rf_we, done, misaligned, err, data_we}, 32'd0);
    check("rst_bus", data_addr | data_wdata | 32'(data_be) | rf_data, 32'd0);
    tick(); tick();
    rstn = 1'b1;
    check("rel_ready_pre", 32'(ctrl_ready), 32'd0);
    tick();
    check("rel_ready_post", 32'(ctrl_ready), 32'd1);

    // lb 0x1003 signed
    request(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 5'd5);
    tick();
    ctrl_valid = 1'b0;
    check("lb_req", 32'(data_req), 32'd1);
    check("lb_ready", 32'(ctrl_ready), 32'd0);
    check("lb_be", 32'(data_be), 32'b1000);
    check("lb_addr", data_addr, 32'h0000_1000);
    check("lb_we", 32'(data_we), 32'd0);
    data_gnt = 1'b1;
    tick();
    data_gnt = 1'b0;
    check("lb_req_off", 32'(data_req), 32'd0);
    data_rvalid = 1'b1;
    data_rdata  = 32'h80FF_FF01;
    tick();
    data_rvalid = 1'b0;
    check("lb_rf_we", 32'(rf_we), 32'd1);
    check("lb_rf_addr", 32'(rf_addr), 32'd5);
    check("lb_rf_data", rf_data, 32'hFFFF_FF80);
    check("lb_done", 32'(done), 32'd1);
    check("lb_ready_back", 32'(ctrl_ready), 32'd1);
    tick();
    check("lb_rf_we_pulse", 32'(rf_we), 32'd0);
    check("lb_done_pulse", 32'(done), 32'd0);

    // sh 0x2002 with grant delayed 3 cycles; a stray rvalid in ADDR is ignored
    request(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd7);
    tick();
    ctrl_valid  = 1'b0;
    data_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("sh_req", 32'(data_req), 32'd1);
      check("sh_be", 32'(data_be), 32'b1100);
      check("sh_wdata", data_wdata, 32'hABCD_ABCD);
      check("sh_addr", data_addr, 32'h0000_2000);
      check("sh_we", 32'(data_we), 32'd1);
      check("sh_no_done", 32'(done), 32'd0);
      if (i == 3) data_gnt = 1'b1;
      tick();
      data_rvalid = 1'b0;
    end
    data_gnt = 1'b0;
    check("sh_req_off", 32'(data_req), 32'd0);
    data_rvalid = 1'b1;
    tick();
    data_rvalid = 1'b0;
    check("sh_done", 32'(done), 32'd1);
    check("sh_no_rf_we", 32'(rf_we), 32'd0);
    tick();

    // lw 0x3001 misaligned
    request(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 5'd1);
    tick();
    ctrl_valid = 1'b0;
    check("lw_mis", 32'(misaligned), 32'd1);
    check("lw_mis_req", 32'(data_req), 32'd0);
    check("lw_mis_ready", 32'(ctrl_ready), 32'd1);
    tick();
    check("lw_mis_pulse", 32'(misaligned), 32'd0);
    check("lw_mis_req2", 32'(data_req), 32'd0);

    // size 11 always illegal
    request(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 5'd1);
    tick();
    ctrl_valid = 1'b0;
    check("sz11_mis", 32'(misaligned), 32'd1);
    check("sz11_req", 32'(data_req), 32'd0);
    tick();

    // lhu 0x4000, minimum latency, then back-to-back sb 0x5001
    request(1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'd0, 5'd3);
    tick();
    ctrl_valid = 1'b0;
    data_gnt   = 1'b1;
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_F00F;
    tick();
    data_rvalid = 1'b0;
    check("lhu_rf_we", 32'(rf_we), 32'd1);
    check("lhu_rf_addr", 32'(rf_addr), 32'd3);
    check("lhu_rf_data", rf_data, 32'h0000_F00F);
    check("lhu_ready", 32'(ctrl_ready), 32'd1);
    request(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00A5, 5'd0);
    tick();
    ctrl_valid = 1'b0;
    check("b2b_req", 32'(data_req), 32'd1);
    check("b2b_be", 32'(data_be), 32'b0010);
    check("b2b_wdata", data_wdata, 32'hA5A5_A5A5);
    check("b2b_rf_we", 32'(rf_we), 32'd0);
    data_gnt = 1'b1;
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    tick();
    data_rvalid = 1'b0;
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_no_rf_we", 32'(rf_we), 32'd0);
    tick();

    // Reset while in RESP, then a late rvalid
    request(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'd0, 5'd9);
    tick();
    ctrl_valid = 1'b0;
    data_gnt   = 1'b1;
    tick();
    data_gnt = 1'b0;
    rstn     = 1'b0;
    #1;
    check("rr_req", 32'(data_req), 32'd0);
    check("rr_ready", 32'(ctrl_ready), 32'd0);
    tick();
    rstn        = 1'b1;
    data_rvalid = 1'b1;
    data_rdata  = 32'hDEAD_BEEF;
    tick();
    data_rvalid = 1'b0;
    check("rr_no_rf_we", 32'(rf_we), 32'd0);
    check("rr_no_done", 32'(done), 32'd0);
    check("rr_ready_back", 32'(ctrl_ready), 32'd1);
    tick();

    // lw 0x7000 answered with data_err
    request(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'd0, 5'd4);
    tick();
    ctrl_valid = 1'b0;
    data_gnt   = 1'b1;
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_err    = 1'b1;
    data_rdata  = 32'h1122_3344;
    tick();
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    check("err_done", 32'(done), 32'd1);
`ifdef JEDRO_1_LSU_ERR_EN
    check("err_err", 32'(err), 32'd1);
    check("err_rf_we", 32'(rf_we), 32'd0);
`else
    check("err_err", 32'(err), 32'd0);
    check("err_rf_we", 32'(rf_we), 32'd1);
    check("err_rf_data", rf_data, 32'h1122_3344);
`endif
    tick();
    check("err_pulse", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
